// File: rtl/led_seq_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_seq_engine                                                |
// | Purpose  : LED pattern sequencer driven by raw active-low pushbuttons.   |
// |            Each button is synchronised, debounced and turned into a      |
// |            one-cycle press pulse. The presses select a speed level and   |
// |            one of four patterns (walk, bounce, fill, count) shown on     |
// |            NUM_LEDS outputs.                                             |
// | Ports    : CLK_50      - system clock                                    |
// |            reset       - synchronous active-high reset                   |
// |            pb_freq_up  - raw button (active-low), speed up               |
// |            pb_freq_dn  - raw button (active-low), speed down             |
// |            pb_seq_up   - raw button (active-low), next pattern           |
// |            pb_seq_dn   - raw button (active-low), previous pattern       |
// |            leds        - current pattern frame (registered)              |
// |            speed_lvl   - current speed level, 0 = slowest                |
// |            seq_sel     - current pattern index                           |
// |            step_tick   - one-cycle pulse on each frame advance           |
// | Option   : KROS_PAUSE_EN adds pb_pause (raw, active-low) and paused;     |
// |            each pause press toggles a freeze of the frame advance.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module led_seq_engine #(
  parameter int NUM_LEDS     = 10,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SPEED_LEVELS = 8,
  parameter int BASE_DIV     = 390625,
  parameter int SW           = $clog2(SPEED_LEVELS)
) (
  input  logic                CLK_50,
  input  logic                reset,
  input  logic                pb_freq_up,
  input  logic                pb_freq_dn,
  input  logic                pb_seq_up,
  input  logic                pb_seq_dn,
`ifdef KROS_PAUSE_EN
  input  logic                pb_pause,
  output logic                paused,
`endif
  output logic [NUM_LEDS-1:0] leds,
  output logic [SW-1:0]       speed_lvl,
  output logic [1:0]          seq_sel,
  output logic                step_tick
);

`ifdef KROS_PAUSE_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  // Wide enough for BASE_DIV * 2^(SPEED_LEVELS-1).
  localparam int PW = $clog2(BASE_DIV) + SPEED_LEVELS;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [SW-1:0] SPD_MAX = SW'(SPEED_LEVELS - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] press;

`ifdef KROS_PAUSE_EN
  assign raw = {pb_pause, pb_seq_dn, pb_seq_up, pb_freq_dn, pb_freq_up};
`else
  assign raw = {pb_seq_dn, pb_seq_up, pb_freq_dn, pb_freq_up};
`endif

  // Synchroniser + debouncer per button. Synchroniser flops reset to the
  // released (high) level so a button held through reset is seen as a
  // fresh press once reset drops.
  for (genvar i = 0; i < NB; i++) begin : g_btn
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          level;

    assign level = ~sync2;

    always_ff @(posedge CLK_50) begin
      if (reset) begin
        sync1  <= 1'b1;
        sync2  <= 1'b1;
        stable <= 1'b0;
        cnt    <= '0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        if (level == stable) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          stable <= level;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    // High in the cycle whose edge moves stable from released to pressed.
    assign press[i] = level & ~stable & (cnt == DB_LAST);
  end

  logic          spd_inc;
  logic          spd_dec;
  logic          seq_chg;
  logic [1:0]    seq_next;
  logic [SW-1:0] shift;
  logic [PW-1:0] period_m1;
  logic [PW-1:0] presc;
  logic          hold;
  logic          bounce_up;
  logic          fill_up;
  logic [NUM_LEDS-1:0] next_leds;
  logic          next_bounce_up;
  logic          next_fill_up;

  assign spd_inc  = press[0] & ~press[1] & (speed_lvl != SPD_MAX);
  assign spd_dec  = press[1] & ~press[0] & (speed_lvl != '0);
  assign seq_chg  = press[2] ^ press[3];
  assign seq_next = press[2] ? seq_sel + 2'd1 : seq_sel - 2'd1;

  // Step period is BASE_DIV doubled once for every level below the top.
  assign shift     = SPD_MAX - speed_lvl;
  assign period_m1 = (PW'(BASE_DIV) << shift) - PW'(1);

`ifdef KROS_PAUSE_EN
  assign hold = paused;
`else
  assign hold = 1'b0;
`endif

  assign step_tick = (presc == period_m1) & ~hold;

  // Next frame of the active pattern.
  always_comb begin
    next_leds      = leds;
    next_bounce_up = bounce_up;
    next_fill_up   = fill_up;
    case (seq_sel)
      2'd0: next_leds = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
      2'd1: begin
        // Reverse on reaching an end so the end LED is shown only once.
        if (bounce_up) begin
          if (leds[NUM_LEDS-1]) begin
            next_leds      = leds >> 1;
            next_bounce_up = 1'b0;
          end else begin
            next_leds = leds << 1;
          end
        end else begin
          if (leds[0]) begin
            next_leds      = leds << 1;
            next_bounce_up = 1'b1;
          end else begin
            next_leds = leds >> 1;
          end
        end
      end
      2'd2: begin
        if (fill_up) begin
          if (&leds) begin
            next_leds    = leds >> 1;
            next_fill_up = 1'b0;
          end else begin
            next_leds = {leds[NUM_LEDS-2:0], 1'b1};
          end
        end else begin
          if (leds == '0) begin
            next_leds    = NUM_LEDS'(1);
            next_fill_up = 1'b1;
          end else begin
            next_leds = leds >> 1;
          end
        end
      end
      default: next_leds = leds + NUM_LEDS'(1);
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      leds      <= NUM_LEDS'(1);
      speed_lvl <= '0;
      seq_sel   <= 2'd0;
      presc     <= '0;
      bounce_up <= 1'b1;
      fill_up   <= 1'b1;
`ifdef KROS_PAUSE_EN
      paused    <= 1'b0;
`endif
    end else begin
      if (spd_inc) begin
        speed_lvl <= speed_lvl + SW'(1);
      end else if (spd_dec) begin
        speed_lvl <= speed_lvl - SW'(1);
      end

`ifdef KROS_PAUSE_EN
      if (press[4]) begin
        paused <= ~paused;
      end
`endif

      // A pattern change wins over a coincident frame advance.
      if (seq_chg) begin
        seq_sel   <= seq_next;
        leds      <= seq_next[1] ? '0 : NUM_LEDS'(1);
        bounce_up <= 1'b1;
        fill_up   <= 1'b1;
      end else if (step_tick) begin
        leds      <= next_leds;
        bounce_up <= next_bounce_up;
        fill_up   <= next_fill_up;
      end

      if (spd_inc || spd_dec || seq_chg) begin
        presc <= '0;
      end else if (!hold) begin
        presc <= step_tick ? '0 : presc + PW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_seq_engine                                             |
// | Purpose  : Directed self-checking bench for led_seq_engine with          |
// |            NUM_LEDS=4, DEBOUNCE_CYC=4, SPEED_LEVELS=4, BASE_DIV=2.       |
// |            Compile with KROS_PAUSE_EN to also cover the pause option.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_led_seq_engine;

`ifdef KROS_PAUSE_EN
  localparam int NPB = 5;
`else
  localparam int NPB = 4;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NPB-1:0] pb = '1;
  logic [3:0]     leds;
  logic [1:0]     speed_lvl;
  logic [1:0]     seq_sel;
  logic           step_tick;
`ifdef KROS_PAUSE_EN
  logic           paused;
`endif

  int checks = 0;
  int errors = 0;

  led_seq_engine #(
    .NUM_LEDS(4), .DEBOUNCE_CYC(4), .SPEED_LEVELS(4), .BASE_DIV(2)
  ) dut (
    .CLK_50    (clk),
    .reset     (reset),
    .pb_freq_up(pb[0]),
    .pb_freq_dn(pb[1]),
    .pb_seq_up (pb[2]),
    .pb_seq_dn (pb[3]),
`ifdef KROS_PAUSE_EN
    .pb_pause  (pb[4]),
    .paused    (paused),
`endif
    .leds      (leds),
    .speed_lvl (speed_lvl),
    .seq_sel   (seq_sel),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle long enough for any earlier release to settle, then hold the
  // button exactly until the edge that applies its press (6 edges).
  task automatic press(input int idx);
    repeat (8) step();
    pb[idx] = 1'b0;
    repeat (6) step();
    pb[idx] = 1'b1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (step_tick !== 1'b1 && n < 300);
    if (step_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no step_tick within %0d cycles, need one", n);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL reset_leds got %b need 0001", leds); end
    checks++; if (speed_lvl !== 2'd0) begin errors++; $display("FAIL reset_speed got %0d need 0", speed_lvl); end
    checks++; if (seq_sel !== 2'd0) begin errors++; $display("FAIL reset_seq got %0d need 0", seq_sel); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b need 0", step_tick); end
    reset = 1'b0;
  endtask

  task automatic test_walk();
    int n;
    logic [3:0] exp [4];
    exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      checks++; if (n !== 15) begin errors++; $display("FAIL walk_period[%0d] got %0d need 15", i, n); end
      step();
      checks++; if (leds !== exp[i]) begin errors++; $display("FAIL walk_frame[%0d] got %b need %b", i, leds, exp[i]); end
    end
  endtask

  task automatic test_bounce();
    int n;
    logic [3:0] exp [7];
    exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    pb[2] = 1'b0;
    repeat (3) step();
    pb[2] = 1'b1;
    repeat (10) step();
    checks++; if (seq_sel !== 2'd0) begin errors++; $display("FAIL glitch_seq got %0d need 0", seq_sel); end
    pb[2] = 1'b0;
    repeat (6) step();
    checks++; if (seq_sel !== 2'd1) begin errors++; $display("FAIL seq_up got %0d need 1", seq_sel); end
    checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL bounce_f0 got %b need 0001", leds); end
    repeat (6) step();
    pb[2] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_tick(n);
      checks++; if (n !== ((i == 0) ? 9 : 15)) begin errors++; $display("FAIL bounce_period[%0d] got %0d need %0d", i, n, (i == 0) ? 9 : 15); end
      step();
      checks++; if (leds !== exp[i]) begin errors++; $display("FAIL bounce_frame[%0d] got %b need %b", i, leds, exp[i]); end
    end
    checks++; if (seq_sel !== 2'd1) begin errors++; $display("FAIL seq_once got %0d need 1", seq_sel); end
  endtask

  task automatic test_speed();
    int n;
    logic [1:0] exp_up [5];
    logic [1:0] exp_dn [5];
    exp_up = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_dn = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      press(0);
      checks++; if (speed_lvl !== exp_up[i]) begin errors++; $display("FAIL speed_up[%0d] got %0d need %0d", i, speed_lvl, exp_up[i]); end
    end
    wait_tick(n);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      checks++; if (n !== 2) begin errors++; $display("FAIL fast_period[%0d] got %0d need 2", i, n); end
    end
    for (int i = 0; i < 5; i++) begin
      press(1);
      checks++; if (speed_lvl !== exp_dn[i]) begin errors++; $display("FAIL speed_dn[%0d] got %0d need %0d", i, speed_lvl, exp_dn[i]); end
    end
    wait_tick(n);
    wait_tick(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL slow_period got %0d need 16", n); end
  endtask

  task automatic test_count();
    int n;
    press(3);
    checks++; if (seq_sel !== 2'd0) begin errors++; $display("FAIL seq_dn_a got %0d need 0", seq_sel); end
    press(3);
    checks++; if (seq_sel !== 2'd3) begin errors++; $display("FAIL seq_dn_wrap got %0d need 3", seq_sel); end
    checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL count_f0 got %b need 0000", leds); end
    for (int i = 1; i <= 16; i++) begin
      wait_tick(n);
      checks++; if (n !== 15) begin errors++; $display("FAIL count_period[%0d] got %0d need 15", i, n); end
      step();
      checks++; if (leds !== 4'(i)) begin errors++; $display("FAIL count_frame[%0d] got %b need %b", i, leds, 4'(i)); end
    end
    press(2);
    checks++; if (seq_sel !== 2'd0) begin errors++; $display("FAIL seq_up_wrap got %0d need 0", seq_sel); end
    checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL walk_f0 got %b need 0001", leds); end
  endtask

  task automatic test_fill();
    int n;
    logic [3:0] exp [8];
    exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    press(2);
    press(2);
    checks++; if (seq_sel !== 2'd2) begin errors++; $display("FAIL seq_fill got %0d need 2", seq_sel); end
    checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL fill_f0 got %b need 0000", leds); end
    for (int i = 0; i < 8; i++) begin
      wait_tick(n);
      checks++; if (n !== 15) begin errors++; $display("FAIL fill_period[%0d] got %0d need 15", i, n); end
      step();
      checks++; if (leds !== exp[i]) begin errors++; $display("FAIL fill_frame[%0d] got %b need %b", i, leds, exp[i]); end
    end
    repeat (8) step();
    pb[2] = 1'b0; pb[3] = 1'b0;
    repeat (6) step();
    pb[2] = 1'b1; pb[3] = 1'b1;
    repeat (8) step();
    checks++; if (seq_sel !== 2'd2) begin errors++; $display("FAIL seq_both got %0d need 2", seq_sel); end
    pb[0] = 1'b0; pb[1] = 1'b0;
    repeat (6) step();
    pb[0] = 1'b1; pb[1] = 1'b1;
    repeat (8) step();
    checks++; if (speed_lvl !== 2'd0) begin errors++; $display("FAIL speed_both got %0d need 0", speed_lvl); end
  endtask

  task automatic test_reset_mid();
    int n;
    press(3);
    checks++; if (seq_sel !== 2'd1) begin errors++; $display("FAIL seq_to_bounce got %0d need 1", seq_sel); end
    wait_tick(n);
    step();
    checks++; if (leds !== 4'b0010) begin errors++; $display("FAIL mid_bounce got %b need 0010", leds); end
    pb[0] = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL rst_leds got %b need 0001", leds); end
    checks++; if (seq_sel !== 2'd0) begin errors++; $display("FAIL rst_seq got %0d need 0", seq_sel); end
    checks++; if (speed_lvl !== 2'd0) begin errors++; $display("FAIL rst_speed got %0d need 0", speed_lvl); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b need 0", step_tick); end
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    checks++; if (speed_lvl !== 2'd0) begin errors++; $display("FAIL held_early got %0d need 0", speed_lvl); end
    step();
    checks++; if (speed_lvl !== 2'd1) begin errors++; $display("FAIL held_press got %0d need 1", speed_lvl); end
    pb[0] = 1'b1;
    repeat (8) step();
  endtask

`ifdef KROS_PAUSE_EN
  task automatic test_pause();
    int n;
    int bad;
    logic [3:0] frozen;
    press(4);
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_on got %b need 1", paused); end
    frozen = leds;
    bad = 0;
    repeat (100) begin
      step();
      if (step_tick !== 1'b0 || leds !== frozen) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pause_freeze got %0d moving cycles need 0", bad); end
    press(2);
    checks++; if (seq_sel !== 2'd1) begin errors++; $display("FAIL pause_seq got %0d need 1", seq_sel); end
    checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL pause_f0 got %b need 0001", leds); end
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_kept got %b need 1", paused); end
    press(4);
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_off got %b need 0", paused); end
    wait_tick(n);
    checks++; if (n !== 7) begin errors++; $display("FAIL resume_period got %0d need 7", n); end
    step();
    checks++; if (leds !== 4'b0010) begin errors++; $display("FAIL resume_frame got %b need 0010", leds); end
  endtask
`endif

  initial begin
    test_reset();
    test_walk();
    test_bounce();
    test_speed();
    test_count();
    test_fill();
    test_reset_mid();
`ifdef KROS_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
